// File: rtl/aes_subbytes_multi_if.sv
// Handshake and state-array bus between the round pipeline and the SubBytes engine.
// The master drives the request side and next_is_ready; the slave returns ready, valid_out and the result.
interface aes_subbytes_multi_if #(
  parameter int DIM = 4
);
  logic                         valid;
  logic                         inverse;
  logic                         next_is_ready;
  logic [DIM-1:0][DIM-1:0][7:0] state_array;
  logic                         ready;
  logic                         valid_out;
  logic [DIM-1:0][DIM-1:0][7:0] state_array_out;

  modport master (
    output valid, inverse, next_is_ready, state_array,
    input  ready, valid_out, state_array_out
  );

  modport slave (
    input  valid, inverse, next_is_ready, state_array,
    output ready, valid_out, state_array_out
  );
endinterface

// File: rtl/aes_subbytes_multi.sv
// AES SubBytes/InvSubBytes over a DIMxDIM state, BYTES_PER_CYCLE lanes; result valid N=DIM*DIM/BPC cycles after acceptance.
// Accepts only in IDLE (ready); holds the result in DONE until next_is_ready, so back-to-back throughput is one state per N+2 cycles.
module aes_subbytes_multi #(
  parameter int STATE_ARRAY_DIMENSION = 4,
  parameter int BYTES_PER_CYCLE       = 4,
  parameter int ENABLE_INVERSE        = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  aes_subbytes_multi_if.slave  bus
);

  localparam int DIM  = STATE_ARRAY_DIMENSION;
  localparam int NB   = DIM * DIM;
  localparam int BPC  = BYTES_PER_CYCLE;
  localparam int BPCS = (BPC < 1) ? 1 : BPC;
  localparam int NG   = NB / BPCS;
  localparam int CW   = (NG > 1) ? $clog2(NG) : 1;

  generate
    if ((BPC < 1) || ((NB % BPCS) != 0)) begin : g_bad_bpc
      $error("BYTES_PER_CYCLE must be >= 1 and divide STATE_ARRAY_DIMENSION**2");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_DONE    = 2'd2
  } fsm_e;

  typedef logic [DIM-1:0][DIM-1:0][7:0] state_t;
  typedef logic [NB-1:0][7:0]           lin_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse in GF(2^8) as a^254 (maps 0 to 0, as the S-box requires).
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] sq;
    r  = 8'h01;
    sq = a;
    for (int i = 1; i < 8; i++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int k);
    logic [15:0] t;
    t = {b, b} << k;
    return t[15:8];
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] a);
    return ginv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
  endfunction

  fsm_e            fsm_q, fsm_d;
  logic [CW-1:0]   grp_q, grp_d;
  logic            inv_q, inv_d;
  lin_t            cap_q, cap_d;
  state_t          out_q, out_d;

  logic [BPCS-1:0][7:0] lane_in;
  logic [BPCS-1:0][7:0] lane_sub;

  // Captured bytes are kept in processing order: index = column*DIM + row.
  always_comb begin
    lane_in = '0;
    for (int g = 0; g < NG; g++) begin
      if (CW'(g) == grp_q) begin
        for (int l = 0; l < BPCS; l++) begin
          lane_in[l] = cap_q[g*BPCS + l];
        end
      end
    end
  end

  always_comb begin
    lane_sub = '0;
    for (int l = 0; l < BPCS; l++) begin
      if ((ENABLE_INVERSE != 0) && inv_q) lane_sub[l] = sbox_inv(lane_in[l]);
      else                                lane_sub[l] = sbox_fwd(lane_in[l]);
    end
  end

  always_comb begin
    fsm_d = fsm_q;
    grp_d = grp_q;
    inv_d = inv_q;
    cap_d = cap_q;
    out_d = out_q;
    case (fsm_q)
      ST_IDLE: begin
        if (bus.valid) begin
          fsm_d = ST_RUNNING;
          grp_d = '0;
          inv_d = (ENABLE_INVERSE != 0) && bus.inverse;
          for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < DIM; c++) begin
              cap_d[c*DIM + r] = bus.state_array[r][c];
            end
          end
        end
      end
      ST_RUNNING: begin
        for (int i = 0; i < NB; i++) begin
          if (CW'(i / BPCS) == grp_q) out_d[i % DIM][i / DIM] = lane_sub[i % BPCS];
        end
        if (grp_q == CW'(NG - 1)) begin
          fsm_d = ST_DONE;
          grp_d = '0;
        end else begin
          grp_d = grp_q + CW'(1);
        end
      end
      ST_DONE: begin
        if (bus.next_is_ready) fsm_d = ST_IDLE;
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fsm_q <= ST_IDLE;
      grp_q <= '0;
      inv_q <= 1'b0;
      cap_q <= '0;
      out_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      grp_q <= grp_d;
      inv_q <= inv_d;
      cap_q <= cap_d;
      out_q <= out_d;
    end
  end

  assign bus.ready           = (fsm_q == ST_IDLE);
  assign bus.valid_out       = (fsm_q == ST_DONE);
  assign bus.state_array_out = out_q;

endmodule

// File: tb/tb_aes_subbytes_multi.sv
// Directed-plus-random bench for aes_subbytes_multi against a table-driven S-box model.
module tb_aes_subbytes_multi;

  localparam logic [127:0] APPB_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] APPB_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam int NSW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  aes_subbytes_multi_if #(.DIM(4)) m();
  aes_subbytes_multi #(
    .STATE_ARRAY_DIMENSION(4),
    .BYTES_PER_CYCLE(4),
    .ENABLE_INVERSE(1)
  ) dut (
    .clk(clk),
    .reset_n(rst_n),
    .bus(m)
  );

  logic         sw_valid;
  logic         sw_inverse;
  logic         sw_nir;
  logic [127:0] sw_in;
  logic [127:0] sw_out [NSW];
  logic         sw_vout [NSW];

  function automatic int bpc_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 2 : (k == 2) ? 8 : (k == 3) ? 16 : 4;
  endfunction

  for (genvar k = 0; k < NSW; k++) begin : g_sw
    aes_subbytes_multi_if #(.DIM(4)) sif();
    assign sif.valid         = sw_valid;
    assign sif.inverse       = sw_inverse;
    assign sif.next_is_ready = sw_nir;
    assign sif.state_array   = sw_in;
    assign sw_out[k]         = sif.state_array_out;
    assign sw_vout[k]        = sif.valid_out;
    aes_subbytes_multi #(
      .STATE_ARRAY_DIMENSION(4),
      .BYTES_PER_CYCLE(bpc_of(k)),
      .ENABLE_INVERSE((k == 4) ? 0 : 1)
    ) u_sw (
      .clk(clk),
      .reset_n(rst_n),
      .bus(sif)
    );
  end

  logic [127:0] sb_rows [16] = '{
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  logic [7:0] sb  [256];
  logic [7:0] isb [256];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Column-major byte list (row fastest) <-> packed [row][col] state.
  function automatic logic [127:0] to_state(input logic [127:0] seq);
    logic [127:0] st;
    st = '0;
    for (int i = 0; i < 16; i++) st[((i % 4) * 4 + i / 4) * 8 +: 8] = seq[127 - 8*i -: 8];
    return st;
  endfunction

  function automatic logic [127:0] from_state(input logic [127:0] st);
    logic [127:0] seq;
    seq = '0;
    for (int i = 0; i < 16; i++) seq[127 - 8*i -: 8] = st[((i % 4) * 4 + i / 4) * 8 +: 8];
    return seq;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] st, input logic inv);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = inv ? isb[st[8*i +: 8]] : sb[st[8*i +: 8]];
    return r;
  endfunction

  task automatic xact(input logic [127:0] st, input logic inv, output logic [127:0] res, output int lat);
    int w;
    w = 0;
    m.state_array = st;
    m.inverse     = inv;
    m.valid       = 1'b1;
    while (!m.ready && w < 20) begin
      tick();
      w++;
    end
    if (!m.ready) check("accept_timeout", m.ready, 1);
    tick();
    m.valid = 1'b0;
    lat = 0;
    while (!m.valid_out && lat < 40) begin
      m.state_array = rand128();
      m.inverse     = 1'($urandom);
      tick();
      lat++;
    end
    res = m.state_array_out;
  endtask

  task automatic release_done(input string tag);
    m.valid         = 1'b0;
    m.next_is_ready = 1'b1;
    tick();
    check({tag, "_ready"}, m.ready, 1);
    check({tag, "_vout"}, m.valid_out, 0);
    m.next_is_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] res;
    logic [127:0] st;
    logic [127:0] exp;
    logic         inv;
    logic         rb;
    int           lat;
    int           last_acc;
    int           swl [NSW];
    logic [127:0] swr [NSW];
    logic [127:0] exp_q [$];

    for (int i = 0; i < 16; i++) begin
      logic [127:0] row;
      row = sb_rows[i];
      for (int j = 0; j < 16; j++) sb[i*16 + j] = row[127 - 8*j -: 8];
    end
    for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);

    rst_n           = 1'b0;
    m.valid         = 1'b1;
    m.inverse       = 1'b0;
    m.next_is_ready = 1'b0;
    m.state_array   = rand128();
    sw_valid        = 1'b0;
    sw_inverse      = 1'b0;
    sw_nir          = 1'b0;
    sw_in           = '0;

    // Reset held for two edges with valid asserted.
    tick();
    tick();
    check("rst_ready", m.ready, 1);
    check("rst_vout", m.valid_out, 0);
    check("rst_out", m.state_array_out, '0);
    m.valid = 1'b0;
    rst_n   = 1'b1;
    tick();
    check("rst_still_idle", m.ready, 1);

    // FIPS-197 Appendix B, forward then inverse round trip.
    xact(to_state(APPB_IN), 1'b0, res, lat);
    check("appb_fwd", from_state(res), APPB_OUT);
    check("appb_fwd_lat", lat, 4);
    release_done("appb_fwd_rel");
    xact(res, 1'b1, res, lat);
    check("appb_inv", from_state(res), APPB_IN);
    check("appb_inv_lat", lat, 4);
    release_done("appb_inv_rel");

    xact({16{8'h63}}, 1'b1, res, lat);
    check("all63_inv", res, '0);
    release_done("all63_rel");
    xact('0, 1'b0, res, lat);
    check("all00_fwd", res, {16{8'h63}});
    release_done("all00_rel");

    // Random transactions with a short random hold in DONE.
    for (int t = 0; t < 8; t++) begin
      st  = rand128();
      inv = 1'($urandom);
      exp = model(st, inv);
      xact(st, inv, res, lat);
      check("rand_data", res, exp);
      check("rand_lat", lat, 4);
      for (int h = 0; h < int'($urandom_range(0, 3)); h++) begin
        tick();
        check("rand_hold", m.state_array_out, exp);
      end
      release_done("rand_rel");
    end

    // Backpressure: ten cycles of next_is_ready low with noisy inputs.
    st  = rand128();
    inv = 1'($urandom);
    exp = model(st, inv);
    xact(st, inv, res, lat);
    check("bp_data", res, exp);
    for (int h = 0; h < 10; h++) begin
      m.state_array = rand128();
      m.inverse     = 1'($urandom);
      m.valid       = 1'($urandom);
      tick();
      check("bp_vout", m.valid_out, 1);
      check("bp_out", m.state_array_out, exp);
    end
    release_done("bp_rel");

    // Back-to-back with valid and next_is_ready held high.
    m.next_is_ready = 1'b1;
    m.valid         = 1'b1;
    m.state_array   = rand128();
    m.inverse       = 1'($urandom);
    last_acc        = -1;
    for (int t = 0; t < 40; t++) begin
      rb = m.ready;
      tick();
      if (rb) begin
        if (last_acc >= 0) check("b2b_interval", t - last_acc, 6);
        last_acc = t;
        exp_q.push_back(model(m.state_array, m.inverse));
        m.state_array = rand128();
        m.inverse     = 1'($urandom);
      end
      check("b2b_excl", m.ready & m.valid_out, 0);
      if (m.valid_out) begin
        if (exp_q.size() == 0) check("b2b_extra", m.valid_out, 0);
        else check("b2b_data", m.state_array_out, exp_q.pop_front());
      end
    end
    m.valid = 1'b0;
    for (int t = 0; t < 12; t++) begin
      tick();
      if (m.valid_out && exp_q.size() != 0) check("b2b_drain_data", m.state_array_out, exp_q.pop_front());
    end
    check("b2b_drain_empty", exp_q.size(), 0);
    check("b2b_idle", m.ready, 1);
    m.next_is_ready = 1'b0;

    // Reset asserted at the second RUNNING edge.
    m.state_array = rand128();
    m.valid       = 1'b1;
    tick();
    m.valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    check("mid_rst_ready", m.ready, 1);
    check("mid_rst_vout", m.valid_out, 0);
    check("mid_rst_out", m.state_array_out, '0);
    rst_n = 1'b1;
    xact(to_state(APPB_IN), 1'b0, res, lat);
    check("mid_rst_after", from_state(res), APPB_OUT);
    check("mid_rst_lat", lat, 4);
    release_done("mid_rst_rel");

    // Parameter sweep: pass 0 forward, pass 1 inverse (instance 4 has no inverse table).
    for (int p = 0; p < 2; p++) begin
      sw_in      = to_state(APPB_IN);
      sw_inverse = 1'(p);
      sw_valid   = 1'b1;
      tick();
      sw_valid   = 1'b0;
      sw_in      = rand128();
      sw_inverse = 1'($urandom);
      for (int k = 0; k < NSW; k++) begin
        swl[k] = -1;
        swr[k] = '0;
      end
      for (int c = 1; c <= 40; c++) begin
        tick();
        for (int k = 0; k < NSW; k++) begin
          if (sw_vout[k] && swl[k] < 0) begin
            swl[k] = c;
            swr[k] = sw_out[k];
          end
        end
      end
      for (int k = 0; k < NSW; k++) begin
        exp = (p == 0 || k == 4) ? to_state(APPB_OUT) : model(to_state(APPB_IN), 1'b1);
        check($sformatf("sweep_p%0d_k%0d_data", p, k), swr[k], exp);
        check($sformatf("sweep_p%0d_k%0d_lat", p, k), swl[k], 16 / bpc_of(k));
      end
      sw_nir = 1'b1;
      tick();
      sw_nir = 1'b0;
      for (int k = 0; k < NSW; k++) check($sformatf("sweep_p%0d_k%0d_rel", p, k), sw_vout[k], 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
